trivium_decrypt: RTL and testbench

//  Receive-side Trivium stream cipher. Recovers plaintext bytes from ciphertext produced by the link's Trivium encryptor.

---
 rtl/trivium_decrypt_pkg.sv | 79 +++++++
 rtl/trivium_decrypt_if.sv | 25 ++
 rtl/trivium_decrypt_core.sv | 40 ++++
 rtl/trivium_decrypt.sv | 147 ++++++++++++++
 tb/tb_trivium_decrypt.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trivium_decrypt_pkg.sv
// Trivium decryptor shared definitions: register lengths, tap positions,
// FSM state encoding and the 8-round combinational step function.
package trivium_decrypt_pkg;

  localparam int unsigned KEY_LEN             = 80;
  localparam int unsigned IV_LEN              = 80;
  localparam int unsigned INIT_ROUNDS_DEFAULT = 1152;
  localparam int unsigned STEP_ROUNDS         = 8;
  localparam int unsigned CNT_W               = 8;

  localparam int unsigned A_LEN = 93;
  localparam int unsigned B_LEN = 84;
  localparam int unsigned C_LEN = 111;

  // Tap positions (index 0 is the newest bit of each register)
  localparam int unsigned A_T   = 65;
  localparam int unsigned A_OUT = 92;
  localparam int unsigned A_FB  = 68;
  localparam int unsigned A_AN0 = 90;
  localparam int unsigned A_AN1 = 91;
  localparam int unsigned B_T   = 68;
  localparam int unsigned B_OUT = 83;
  localparam int unsigned B_FB  = 77;
  localparam int unsigned B_AN0 = 81;
  localparam int unsigned B_AN1 = 82;
  localparam int unsigned C_T   = 65;
  localparam int unsigned C_OUT = 110;
  localparam int unsigned C_FB  = 86;
  localparam int unsigned C_AN0 = 108;
  localparam int unsigned C_AN1 = 109;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_KEY,
    ST_LOAD_IV,
    ST_LOAD_STATE,
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [A_LEN-1:0] a;
    logic [B_LEN-1:0] b;
    logic [C_LEN-1:0] c;
    logic [7:0]       z;
  } step8_t;

  // Eight Trivium rounds; z bit i is the keystream bit of round i
  function automatic step8_t trivium_step8(input logic [A_LEN-1:0] a_in,
                                           input logic [B_LEN-1:0] b_in,
                                           input logic [C_LEN-1:0] c_in);
    step8_t           res;
    logic [A_LEN-1:0] a;
    logic [B_LEN-1:0] b;
    logic [C_LEN-1:0] c;
    logic             t1, t2, t3, fa, fb, fc;
    a     = a_in;
    b     = b_in;
    c     = c_in;
    res.z = '0;
    for (int i = 0; i < STEP_ROUNDS; i++) begin
      t1       = a[A_T] ^ a[A_OUT];
      t2       = b[B_T] ^ b[B_OUT];
      t3       = c[C_T] ^ c[C_OUT];
      res.z[i] = t1 ^ t2 ^ t3;
      fa       = t3 ^ (c[C_AN0] & c[C_AN1]) ^ a[A_FB];
      fb       = t1 ^ (a[A_AN0] & a[A_AN1]) ^ b[B_FB];
      fc       = t2 ^ (b[B_AN0] & b[B_AN1]) ^ c[C_FB];
      a        = {a[A_LEN-2:0], fa};
      b        = {b[B_LEN-2:0], fb};
      c        = {c[C_LEN-2:0], fc};
    end
    res.a = a;
    res.b = b;
    res.c = c;
    return res;
  endfunction

endpackage

// File: rtl/trivium_decrypt_if.sv
// Decryptor link bundle: serial key/IV load, ciphertext in, plaintext out, status.
interface trivium_decrypt_if;
  logic       key_bit;
  logic       key_strb;
  logic       iv_bit;
  logic       iv_strb;
  logic [7:0] cipher;
  logic       cipher_valid;
  logic       cipher_ready;
  logic [7:0] plain;
  logic       plain_valid;
  logic       plain_ready;
  logic       busy;
  logic       err_sgn;

  modport master (
    output key_bit, key_strb, iv_bit, iv_strb, cipher, cipher_valid, plain_ready,
    input  cipher_ready, plain, plain_valid, busy, err_sgn
  );

  modport slave (
    input  key_bit, key_strb, iv_bit, iv_strb, cipher, cipher_valid, plain_ready,
    output cipher_ready, plain, plain_valid, busy, err_sgn
  );
endinterface

// File: rtl/trivium_decrypt_core.sv
// Trivium state holder: loads key/IV, advances 8 rounds per step, exposes the
// keystream byte of the next step. Shared with the encryptor.
module trivium_decrypt_core
  import trivium_decrypt_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [KEY_LEN-1:0] i_key,
  input  logic [IV_LEN-1:0]  i_iv,
  output logic [7:0]         o_z_c
);

  logic [A_LEN-1:0] r_a;
  logic [B_LEN-1:0] r_b;
  logic [C_LEN-1:0] r_c;
  step8_t           w_nxt;

  assign w_nxt = trivium_step8(r_a, r_b, r_c);
  assign o_z_c = w_nxt.z;

  // State load or 8-round advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else if (i_load) begin
      r_a <= {{(A_LEN-KEY_LEN){1'b0}}, i_key};
      r_b <= {{(B_LEN-IV_LEN){1'b0}}, i_iv};
      r_c <= {3'b111, {(C_LEN-3){1'b0}}};
    end else if (i_step) begin
      r_a <= w_nxt.a;
      r_b <= w_nxt.b;
      r_c <= w_nxt.c;
    end
  end

endmodule

// File: rtl/trivium_decrypt.sv
// Receive-side Trivium decryptor: serial key (and optional IV) load, warm-up,
// then one keystream byte XORed onto each accepted ciphertext byte.
// Build option: TRIVIUM_DEC_IV_EN adds a serial IV load phase; otherwise IV = 0.
module trivium_decrypt
  import trivium_decrypt_pkg::*;
#(
  parameter int unsigned INIT_ROUNDS = INIT_ROUNDS_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  trivium_decrypt_if.slave  bus
);

  localparam int unsigned INIT_CLKS = INIT_ROUNDS / STEP_ROUNDS;

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [KEY_LEN-1:0] r_key_sr;
  logic [7:0]         r_plain;
  logic               r_plain_valid;
  logic               r_busy;
  logic               r_err;

  logic [IV_LEN-1:0]  w_iv;
  logic [7:0]         w_z;
  logic               w_ready;
  logic               w_accept;
  logic               w_key_start;
  logic               w_err;

  // A key strobe outside the key/IV load phases starts a fresh key (bit 0)
  assign w_key_start = bus.key_strb &
                       (r_state inside {ST_IDLE, ST_LOAD_STATE, ST_INIT, ST_RUN});
  // Rekey has priority over a byte transfer in the same cycle
  assign w_ready     = (r_state == ST_RUN) & ~bus.key_strb &
                       (~r_plain_valid | bus.plain_ready);
  assign w_accept    = w_ready & bus.cipher_valid;

`ifdef TRIVIUM_DEC_IV_EN
  logic [IV_LEN-1:0] r_iv_sr;
  assign w_iv  = r_iv_sr;
  assign w_err = (bus.cipher_valid & ~(r_state inside {ST_IDLE, ST_RUN})) |
                 (bus.iv_strb & (r_state != ST_LOAD_IV));
`else
  logic w_unused_iv;
  assign w_iv        = '0;
  assign w_unused_iv = bus.iv_bit ^ bus.iv_strb;
  assign w_err       = bus.cipher_valid & ~(r_state inside {ST_IDLE, ST_RUN});
`endif

  trivium_decrypt_core u_core (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == ST_LOAD_STATE),
    .i_step ((r_state == ST_INIT) | w_accept),
    .i_key  (r_key_sr),
    .i_iv   (w_iv),
    .o_z_c  (w_z)
  );

  // Control FSM, key/IV shifters, counters and plaintext holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_key_sr      <= '0;
      r_plain       <= '0;
      r_plain_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
`ifdef TRIVIUM_DEC_IV_EN
      r_iv_sr       <= '0;
`endif
    end else begin
      r_err <= w_err;
      if (w_key_start) begin
        r_key_sr      <= {r_key_sr[KEY_LEN-2:0], bus.key_bit};
        r_cnt         <= CNT_W'(1);
        r_state       <= ST_LOAD_KEY;
        r_busy        <= 1'b1;
        r_plain_valid <= 1'b0;
        r_plain       <= '0;
      end else begin
        case (r_state)
          ST_LOAD_KEY: begin
            if (bus.key_strb) begin
              r_key_sr <= {r_key_sr[KEY_LEN-2:0], bus.key_bit};
              if (r_cnt == CNT_W'(KEY_LEN-1)) begin
                r_cnt <= '0;
`ifdef TRIVIUM_DEC_IV_EN
                r_state <= ST_LOAD_IV;
`else
                r_state <= ST_LOAD_STATE;
`endif
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
`ifdef TRIVIUM_DEC_IV_EN
          ST_LOAD_IV: begin
            if (bus.iv_strb) begin
              r_iv_sr <= {r_iv_sr[IV_LEN-2:0], bus.iv_bit};
              if (r_cnt == CNT_W'(IV_LEN-1)) begin
                r_cnt   <= '0;
                r_state <= ST_LOAD_STATE;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
`endif
          ST_LOAD_STATE: begin
            r_cnt   <= '0;
            r_state <= ST_INIT;
          end
          ST_INIT: begin
            if (r_cnt == CNT_W'(INIT_CLKS-1)) begin
              r_cnt   <= '0;
              r_state <= ST_RUN;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (w_accept) begin
              r_plain       <= bus.cipher ^ w_z;
              r_plain_valid <= 1'b1;
            end else if (bus.plain_ready) begin
              r_plain_valid <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.cipher_ready = w_ready;
  assign bus.plain        = r_plain;
  assign bus.plain_valid  = r_plain_valid;
  assign bus.busy         = r_busy;
  assign bus.err_sgn      = r_err;

endmodule

// File: tb/tb_trivium_decrypt.sv
// Directed bench for trivium_decrypt (default build, fixed zero IV).
module tb_trivium_decrypt;

  logic clk;
  logic rst;

  trivium_decrypt_if bus_if ();

  trivium_decrypt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [7:0] cipher;
    logic [7:0] exp_plain;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] ks0[16];
  logic [7:0] ksk[256];

  localparam logic [79:0] KEY0 = 80'h0;
  localparam logic [79:0] KEYK = 80'h0123456789ABCDEF0123;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference Trivium using the classic s1..s288 numbering
  task automatic model_byte(inout logic [288:1] s, output logic [7:0] z);
    logic t1, t2, t3, n1, n2, n3;
    for (int r = 0; r < 8; r++) begin
      t1   = s[66] ^ s[93];
      t2   = s[162] ^ s[177];
      t3   = s[243] ^ s[288];
      z[r] = t1 ^ t2 ^ t3;
      n1   = t1 ^ (s[91] & s[92]) ^ s[171];
      n2   = t2 ^ (s[175] & s[176]) ^ s[264];
      n3   = t3 ^ (s[286] & s[287]) ^ s[69];
      s[93:1]    = {s[92:1], n3};
      s[177:94]  = {s[176:94], n1};
      s[288:178] = {s[287:178], n2};
    end
  endtask

  task automatic model_init(input logic [79:0] key, output logic [288:1] s);
    logic [7:0] zz;
    s            = '0;
    s[80:1]      = key;
    s[288:286]   = 3'b111;
    for (int i = 0; i < 144; i++) model_byte(s, zz);
  endtask

  // Shift key bits hi..0 (MSB first), one strobe per clock
  task automatic load_bits(input logic [79:0] key, input int hi, output bit busy_ok);
    busy_ok = 1'b1;
    for (int i = hi; i >= 0; i--) begin
      bus_if.key_bit  = key[i];
      bus_if.key_strb = 1'b1;
      tick();
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
    end
    bus_if.key_strb = 1'b0;
    bus_if.key_bit  = 1'b0;
  endtask

  // Count clocks until cipher_ready rises (bounded)
  task automatic wait_ready(output int cnt, output bit busy_ok);
    cnt     = 0;
    busy_ok = 1'b1;
    while (bus_if.cipher_ready !== 1'b1 && cnt < 400) begin
      tick();
      cnt++;
      if (bus_if.cipher_ready !== 1'b1 && bus_if.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [288:1] s;
    logic [7:0]   z;
    logic [7:0]   p;
    int           cnt;
    bit           bok, bok2, rdy_ok, stab_ok;

    // Golden keystreams
    model_init(KEY0, s);
    for (int i = 0; i < 16; i++) begin model_byte(s, z); ks0[i] = z; end
    model_init(KEYK, s);
    for (int i = 0; i < 256; i++) begin model_byte(s, z); ksk[i] = z; end

    vecs[0] = '{cipher: 8'h00,            exp_plain: ks0[0]};
    vecs[1] = '{cipher: 8'hFF,            exp_plain: ~ks0[1]};
    vecs[2] = '{cipher: 8'h5A ^ ks0[2],   exp_plain: 8'h5A};
    vecs[3] = '{cipher: 8'h00 ^ ks0[3],   exp_plain: 8'h00};
    vecs[4] = '{cipher: 8'hC3 ^ ks0[4],   exp_plain: 8'hC3};
    vecs[5] = '{cipher: 8'h81 ^ ks0[5],   exp_plain: 8'h81};

    bus_if.key_bit      = 1'b0;
    bus_if.key_strb     = 1'b0;
    bus_if.iv_bit       = 1'b0;
    bus_if.iv_strb      = 1'b0;
    bus_if.cipher       = 8'h00;
    bus_if.cipher_valid = 1'b0;
    bus_if.plain_ready  = 1'b1;
    rst                 = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_plain",       32'(bus_if.plain),        32'h0);
    chk("rst_plain_valid", 32'(bus_if.plain_valid),  32'h0);
    chk("rst_busy",        32'(bus_if.busy),         32'h0);
    chk("rst_err",         32'(bus_if.err_sgn),      32'h0);
    chk("rst_ready",       32'(bus_if.cipher_ready), 32'h0);
    rst = 1'b0;
    tick();

    // Key 0 load and warm-up timing
    load_bits(KEY0, 79, bok);
    chk("busy_during_key", 32'(bok), 32'h1);
    wait_ready(cnt, bok2);
    chk("ready_latency",    32'(cnt),         32'd145);
    chk("busy_during_init", 32'(bok2),        32'h1);
    chk("busy_in_run",      32'(bus_if.busy), 32'h0);

    // Table of back-to-back bytes
    for (int i = 0; i < 6; i++) begin
      bus_if.cipher       = vecs[i].cipher;
      bus_if.cipher_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus_if.plain_valid), 32'h1);
      chk($sformatf("vec%0d_plain", i), 32'(bus_if.plain), 32'(vecs[i].exp_plain));
    end
    bus_if.cipher_valid = 1'b0;
    tick();
    chk("drain_clears_valid", 32'(bus_if.plain_valid), 32'h0);

    // Backpressure: stall 5 clocks, then release
    bus_if.plain_ready  = 1'b0;
    bus_if.cipher       = 8'h11 ^ ks0[6];
    bus_if.cipher_valid = 1'b1;
    tick();
    chk("bp_first", 32'({bus_if.plain_valid, bus_if.plain}), 32'h111);
    bus_if.cipher = 8'h22 ^ ks0[7];
    rdy_ok  = 1'b1;
    stab_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus_if.cipher_ready !== 1'b0) rdy_ok = 1'b0;
      tick();
      if (bus_if.plain !== 8'h11 || bus_if.plain_valid !== 1'b1) stab_ok = 1'b0;
    end
    chk("bp_ready_low",    32'(rdy_ok),         32'h1);
    chk("bp_plain_stable", 32'(stab_ok),        32'h1);
    chk("bp_no_err",       32'(bus_if.err_sgn), 32'h0);
    bus_if.plain_ready = 1'b1;
    tick();
    chk("bp_rel0", 32'({bus_if.plain_valid, bus_if.plain}), 32'h122);
    bus_if.cipher = 8'h33 ^ ks0[8];
    tick();
    chk("bp_rel1", 32'({bus_if.plain_valid, bus_if.plain}), 32'h133);
    bus_if.cipher = 8'h44 ^ ks0[9];
    tick();
    chk("bp_rel2", 32'({bus_if.plain_valid, bus_if.plain}), 32'h144);
    bus_if.cipher_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(bus_if.plain_valid), 32'h0);

    // Rekey in RUN with a pending byte and a simultaneous ciphertext offer
    bus_if.plain_ready  = 1'b0;
    bus_if.cipher       = 8'h55 ^ ks0[10];
    bus_if.cipher_valid = 1'b1;
    tick();
    chk("pending_plain", 32'({bus_if.plain_valid, bus_if.plain}), 32'h155);
    bus_if.plain_ready = 1'b1;
    bus_if.key_bit     = KEYK[79];
    bus_if.key_strb    = 1'b1;
    #1;
    chk("rekey_ready_forced_low", 32'(bus_if.cipher_ready), 32'h0);
    tick();
    bus_if.cipher_valid = 1'b0;
    chk("rekey_plain_valid", 32'(bus_if.plain_valid), 32'h0);
    chk("rekey_busy",        32'(bus_if.busy),        32'h1);
    load_bits(KEYK, 78, bok);
    chk("rekey_busy_during_key", 32'(bok), 32'h1);

    // Ciphertext during warm-up: one-cycle error, byte dropped
    for (int i = 0; i < 10; i++) tick();
    bus_if.cipher       = 8'hEE;
    bus_if.cipher_valid = 1'b1;
    tick();
    bus_if.cipher_valid = 1'b0;
    chk("init_err_pulse", 32'(bus_if.err_sgn),     32'h1);
    chk("init_byte_drop", 32'(bus_if.plain_valid), 32'h0);
    tick();
    chk("init_err_one_clk", 32'(bus_if.err_sgn), 32'h0);
    wait_ready(cnt, bok2);
    chk("rekey_ready_latency", 32'(cnt),  32'd133);
    chk("rekey_busy_init",     32'(bok2), 32'h1);

    // Round trip: 256 bytes encrypted with the reference keystream
    for (int i = 0; i < 256; i++) begin
      p                   = 8'(i);
      bus_if.cipher       = p ^ ksk[i];
      bus_if.cipher_valid = 1'b1;
      tick();
      chk($sformatf("rt%0d", i), 32'({bus_if.plain_valid, bus_if.plain}), 32'({1'b1, p}));
    end
    bus_if.cipher_valid = 1'b0;
    tick();

    // Reset mid-warm-up
    load_bits(KEY0, 79, bok);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy",  32'(bus_if.busy),         32'h0);
    chk("midrst_pv",    32'(bus_if.plain_valid),  32'h0);
    chk("midrst_plain", 32'(bus_if.plain),        32'h0);
    chk("midrst_err",   32'(bus_if.err_sgn),      32'h0);
    chk("midrst_ready", 32'(bus_if.cipher_ready), 32'h0);
    tick();
    chk("midrst_busy_next", 32'(bus_if.busy), 32'h0);
    rst = 1'b0;
    tick();

    // Back in IDLE: ciphertext is ignored without error, then a clean restart
    bus_if.cipher_valid = 1'b1;
    tick();
    bus_if.cipher_valid = 1'b0;
    chk("idle_no_err", 32'(bus_if.err_sgn), 32'h0);
    load_bits(KEY0, 79, bok);
    wait_ready(cnt, bok2);
    chk("restart_latency", 32'(cnt), 32'd145);
    bus_if.cipher       = 8'h00;
    bus_if.cipher_valid = 1'b1;
    tick();
    bus_if.cipher_valid = 1'b0;
    chk("restart_z0", 32'({bus_if.plain_valid, bus_if.plain}), 32'({1'b1, ks0[0]}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
